// File: rtl/axi_transaction_pkg.sv
// Shared AXI transaction payload types used by masters and slaves.
package axi_transaction;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
endpackage

// File: rtl/axi_write_master_pkg.sv
// Configuration constants for the AXI write master.
package axi_write_master_pkg;
  localparam int AXI_MAX_OUTSTANDING_DEFAULT = 4;
endpackage

// File: rtl/axi_valid_hold_reg.sv
// Payload register with valid flag: holds until handshake, reloads on load.
module axi_valid_hold_reg #(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  T     load_data,
  input  logic ready,
  output logic valid,
  output T     data
);
  // load is only asserted when the slot is free, so it wins over the drop
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/axi_write_master.sv
// AXI write master: local request port to independent AW/W channels, B counting.
module axi_write_master
  import axi_transaction::*;
  import axi_write_master_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = AXI_MAX_OUTSTANDING_DEFAULT,
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  addr_t            req_addr,
  input  data_t            req_data,
  output addr_t            awaddr,
  output logic             awvalid,
  input  logic             awready,
  output data_t            wdata,
  output logic             wvalid,
  input  logic             wready,
  input  logic             bvalid,
  output logic             bready,
  output logic [CNT_W-1:0] outstanding,
  output logic [31:0]      done_count,
  output logic             idle,
  output logic             err_unexpected_b
);
  logic aw_free, w_free, accept, b_hs, b_dec;

  assign aw_free   = ~awvalid | awready;
  assign w_free    = ~wvalid | wready;
  // full blocks acceptance even when a B frees a slot this cycle
  assign req_ready = aw_free & w_free & (outstanding < CNT_W'(MAX_OUTSTANDING)) & ~rst;
  assign accept    = req_valid & req_ready;
  assign b_hs      = bvalid & bready;
  assign b_dec     = b_hs & (outstanding != '0);
  assign idle      = (outstanding == '0) & ~awvalid & ~wvalid;

  axi_valid_hold_reg #(.T(addr_t)) u_aw (
    .clk(clk), .rst(rst), .load(accept), .load_data(req_addr),
    .ready(awready), .valid(awvalid), .data(awaddr)
  );

  axi_valid_hold_reg #(.T(data_t)) u_w (
    .clk(clk), .rst(rst), .load(accept), .load_data(req_data),
    .ready(wready), .valid(wvalid), .data(wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bready           <= 1'b0;
      outstanding      <= '0;
      done_count       <= '0;
      err_unexpected_b <= 1'b0;
    end else begin
      bready <= 1'b1;
      if (accept && !b_dec)      outstanding <= outstanding + CNT_W'(1);
      else if (!accept && b_dec) outstanding <= outstanding - CNT_W'(1);
      if (b_hs)                  done_count <= done_count + 32'd1;
      if (b_hs && outstanding == '0) err_unexpected_b <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axi_write_master.sv
// Randomized bench for axi_write_master against a queue-based reference model.
module tb_axi_write_master;
  import axi_transaction::*;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_ready;
  addr_t req_addr = '0, awaddr;
  data_t req_data = '0, wdata;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic [2:0] outstanding;
  logic [31:0] done_count;
  logic idle, err_unexpected_b;

  always #5 clk = ~clk;

  axi_write_master #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready), .outstanding(outstanding),
    .done_count(done_count), .idle(idle), .err_unexpected_b(err_unexpected_b)
  );

  int n_chk = 0, n_fail = 0;

  // reference model state
  addr_t aw_q[$];
  data_t w_q[$];
  int    m_cnt = 0, m_done = 0, m_aw_hs = 0, m_w_hs = 0, m_b_sent = 0, m_acc = 0;
  bit    m_err = 0, m_bready = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (aw_q.size() == 0 || awready) && (w_q.size() == 0 || wready) && m_cnt < MAXO && !rst;
  endfunction

  task automatic check_outputs();
    chk("awvalid", awvalid, aw_q.size() != 0);
    chk("wvalid", wvalid, w_q.size() != 0);
    if (aw_q.size() != 0) chk("awaddr", awaddr, aw_q[0]);
    if (w_q.size() != 0)  chk("wdata", wdata, w_q[0]);
    chk("outstanding", outstanding, m_cnt);
    chk("done_count", done_count, m_done);
    chk("idle", idle, m_cnt == 0 && aw_q.size() == 0 && w_q.size() == 0);
    chk("err", err_unexpected_b, m_err);
    chk("bready", bready, m_bready);
  endtask

  // one clock: drive, check req_ready, advance model across the edge, check outputs
  task automatic cycle(input bit rv, input int paw, input int pw, input int pb, input bit force_b);
    bit acc, bh, pop_aw, pop_w;
    req_valid = rv;
    req_addr  = $urandom;
    req_data  = $urandom;
    awready   = ($urandom_range(0, 99) < paw);
    wready    = ($urandom_range(0, 99) < pw);
    bvalid    = force_b || (!rst && (((m_aw_hs < m_w_hs) ? m_aw_hs : m_w_hs) > m_b_sent)
                            && $urandom_range(0, 99) < pb);
    #1;
    chk("req_ready", req_ready, m_ready());
    acc    = rv && m_ready();
    bh     = bvalid && m_bready;
    pop_aw = aw_q.size() != 0 && awready;
    pop_w  = w_q.size() != 0 && wready;
    @(posedge clk); #1;
    if (rst) begin
      aw_q.delete(); w_q.delete();
      m_cnt = 0; m_done = 0; m_err = 0; m_bready = 0;
      m_aw_hs = 0; m_w_hs = 0; m_b_sent = 0;
    end else begin
      m_bready = 1;
      if (pop_aw) begin void'(aw_q.pop_front()); m_aw_hs++; end
      if (pop_w)  begin void'(w_q.pop_front());  m_w_hs++;  end
      if (acc) begin aw_q.push_back(req_addr); w_q.push_back(req_data); m_acc++; end
      if (bh) begin
        m_done++;
        if (m_cnt == 0) m_err = 1;
        else begin m_cnt--; if (!force_b) m_b_sent++; end
      end
      if (acc) m_cnt++;
    end
    check_outputs();
  endtask

  initial begin
    int a0;
    @(posedge clk); #1;
    cycle(0, 100, 100, 100, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    rst = 1'b0;

    // single directed write
    repeat (3) cycle(0, 100, 100, 100, 0);
    req_valid = 1; req_addr = 32'h10; req_data = 32'hA5; awready = 1; wready = 1; bvalid = 0;
    #1; chk("single_ready", req_ready, 1);
    @(posedge clk); #1;
    chk("single_awv", awvalid, 1); chk("single_awaddr", awaddr, 32'h10);
    chk("single_wv", wvalid, 1);   chk("single_wdata", wdata, 32'hA5);
    chk("single_out", outstanding, 1);
    aw_q.push_back(32'h10); w_q.push_back(32'hA5); m_cnt = 1; m_acc++;
    repeat (5) cycle(0, 100, 100, 100, 0);
    chk("single_done", done_count, 1); chk("single_idle", idle, 1);

    // AW stalled, W free: AW payload held, no new accepts
    cycle(1, 100, 100, 0, 0);
    repeat (10) cycle(1, 0, 100, 100, 0);
    chk("stall_out", outstanding, 1);
    repeat (6) cycle(0, 100, 100, 100, 0);

    // throttle at MAX with B withheld
    a0 = m_acc;
    repeat (10) cycle(1, 100, 100, 0, 0);
    chk("thr_accepts", m_acc - a0, MAXO);
    chk("thr_full_out", outstanding, MAXO);
    repeat (8) cycle(0, 100, 100, 100, 0);
    chk("thr_drain", outstanding, 0);
    a0 = m_acc;
    repeat (3) cycle(1, 100, 100, 100, 0);
    chk("thr_resume", m_acc - a0 > 0, 1);
    repeat (8) cycle(0, 100, 100, 100, 0);

    // 8 back-to-back writes
    a0 = m_acc;
    while (m_acc - a0 < 8) cycle(1, 100, 100, 100, 0);
    repeat (8) cycle(0, 100, 100, 100, 0);
    chk("b2b_done", done_count, m_done);
    chk("b2b_err", err_unexpected_b, 0);

    // randomized traffic
    repeat (300) cycle($urandom_range(0, 1), $urandom_range(0, 100), $urandom_range(0, 100),
                       $urandom_range(0, 100), 0);
    repeat (20) cycle(0, 100, 100, 100, 0);
    chk("rand_idle", idle, 1);

    // unexpected B from a fresh reset state
    rst = 1'b1; cycle(0, 100, 100, 0, 0); rst = 1'b0;
    cycle(0, 100, 100, 0, 0);
    cycle(0, 100, 100, 0, 1);
    chk("unexp_err", err_unexpected_b, 1);
    chk("unexp_out", outstanding, 0);
    chk("unexp_done", done_count, 1);
    repeat (3) cycle(0, 100, 100, 0, 0);
    chk("unexp_sticky", err_unexpected_b, 1);

    // reset mid-transfer with writes outstanding and AW held
    repeat (3) cycle(1, 100, 100, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("pre_rst_awv", awvalid, 1);
    rst = 1'b1; cycle(0, 0, 0, 0, 0); rst = 1'b0;
    chk("rst_awv", awvalid, 0); chk("rst_wv", wvalid, 0); chk("rst_bready", bready, 0);
    chk("rst_out", outstanding, 0); chk("rst_done", done_count, 0); chk("rst_err", err_unexpected_b, 0);
    repeat (3) cycle(1, 100, 100, 100, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_write_master.md
Name: axi_write_master

Overview:
- Synthesizable write-side AXI master that sits directly upstream of `axi_slave`.
- Accepts write commands (address + data) from a local valid/ready request port.
- Drives the AW and W channels independently and consumes B responses.
- Tracks outstanding writes and throttles new requests so no more than MAX_OUTSTANDING are unacknowledged.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unresponded writes; legal range 1..255.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  write command valid.
- req_ready  output  1  write command accepted when req_valid & req_ready.
- req_addr  input  addr_t  command address.
- req_data  input  data_t  command data.
- awaddr  output  addr_t  AW address.
- awvalid  output  1  AW valid.
- awready  input  1  AW ready from slave.
- wdata  output  data_t  W data.
- wvalid  output  1  W valid.
- wready  input  1  W ready from slave.
- bvalid  input  1  B response valid.
- bready  output  1  B ready.
- outstanding  output  CNT_W  current outstanding write count.
- done_count  output  32  total B handshakes since reset; wraps modulo 2^32.
- idle  output  1  high when outstanding==0 & ~awvalid & ~wvalid.
- err_unexpected_b  output  1  sticky; B handshake seen while outstanding==0.

Behaviour:
- Reset (rst high at a clock edge) forces:
  - awvalid=0, wvalid=0, bready=0.
  - outstanding=0, done_count=0, err_unexpected_b=0.
  - awaddr and wdata set to '0.
- bready is registered: 0 during reset, 1 from the first edge with rst low, then held at 1.
- Channel freeness (combinational):
  - aw_free = ~awvalid | awready
  - w_free = ~wvalid | wready
- req_ready = aw_free & w_free & (outstanding < MAX_OUTSTANDING) & ~rst. It is combinational from awready/wready/state and never depends on bvalid.
- Accept at edge N: awvalid=1, awaddr=req_addr, wvalid=1, wdata=req_data, all visible from N+1. Minimum request-to-valid latency is 1 cycle.
- AW channel:
  - While awvalid=1 & awready=0, awvalid and awaddr hold stable.
  - On an AW handshake with no new accept, awvalid drops to 0 next cycle.
  - On an AW handshake with a simultaneous accept, awvalid stays 1 with the new address (back-to-back, 1 write/cycle throughput).
- W channel: identical rules, independent of AW. Either channel may complete first; the other channel keeps holding its payload.
- Outstanding counter:
  - +1 on accept.
  - -1 on B handshake (bvalid & bready) when outstanding>0.
  - Both in the same cycle leave it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- B handshake with outstanding==0: err_unexpected_b set (sticky until reset), counter unchanged, done_count still increments.
- done_count increments by 1 on every B handshake.
- Full: outstanding==MAX_OUTSTANDING forces req_ready=0 even in a cycle where a B handshake frees a slot. The slot becomes available the next cycle.
- Reset mid-transfer drops awvalid/wvalid immediately at that edge; pending payload and count are discarded.
- No ordering or ID tracking: B responses are counted only; the slave returns B in order.

Decomposition:
- addr_t and data_t come from the shared axi_transaction package; no new typedefs.
- Add a package constant AXI_MAX_OUTSTANDING_DEFAULT = 4 for the default.
- One natural sub-module: axi_valid_hold_reg (payload register + valid with the hold/handshake/reload rule), instantiated for AW (addr_t) and W (data_t).

Test Plan:
- Single write, slave ready/response probabilities 100, req_addr=0x10, req_data=0xA5 at cycle 5 → awvalid & wvalid high at cycle 6 with those values; B handshake follows; outstanding returns 0; done_count=1; idle=1.
- AW ready probability 0 for 10 cycles, W probability 100 → W completes at cycle 1; awvalid/awaddr stay stable 10 cycles; req_ready=0 throughout; outstanding=1 until B.
- MAX_OUTSTANDING=2, slave response probability 0, req_valid held high → exactly 2 accepts, then req_ready=0 with outstanding=2; restore probability → 2 B handshakes, outstanding 0, further requests resume.
- 8 back-to-back writes, all probabilities 100, MAX=4 → one accept per cycle while not full; done_count=8; err_unexpected_b=0.
- Force bvalid=1 for one cycle with outstanding=0 → err_unexpected_b=1 (sticky), outstanding stays 0, done_count=1.
- Assert rst with 3 writes outstanding and awvalid high → next cycle awvalid=wvalid=bready=0, outstanding=0, done_count=0, err flag cleared.
